// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage: flag layout,
// ALU control-bit indices and the buffered entry. Macro: ALU_RESULT_PARITY_EN.
package alu_pkg;

    localparam int ALU_W = 16;

`ifdef ALU_RESULT_PARITY_EN
    localparam int FLAG_W = 4;
`else
    localparam int FLAG_W = 3;
`endif

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_P = 3;

    localparam int CTL_ZX = 5;
    localparam int CTL_NX = 4;
    localparam int CTL_ZY = 3;
    localparam int CTL_NY = 2;
    localparam int CTL_F  = 1;
    localparam int CTL_NO = 0;

    typedef struct packed {
        logic [FLAG_W-1:0] flags;
        logic [ALU_W-1:0]  val;
    } entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and its consumer.
// slave: the stage; master: producer/consumer side (bench, ALU, writeback).
interface alu_result_stage_if #(
    parameter int WIDTH = 16
);
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_val;
    logic [5:0]        in_ctrl;
    logic              in_carry;
    logic              in_setflags;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_val;
    logic [FLAG_W-1:0] out_flags;
    logic [FLAG_W-1:0] flags;
    logic [1:0]        count;

    modport slave (
        input  in_valid, in_val, in_ctrl, in_carry, in_setflags, out_ready,
        output in_ready, out_valid, out_val, out_flags, flags, count
    );

    modport master (
        output in_valid, in_val, in_ctrl, in_carry, in_setflags, out_ready,
        input  in_ready, out_valid, out_val, out_flags, flags, count
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational condition-flag generator {P?,C,N,Z} for one ALU result.
// Ports: i_val result, i_f adder-select, i_carry adder carry, o_flags.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0]  i_val,
    input  logic              i_f,
    input  logic              i_carry,
    output logic [FLAG_W-1:0] o_flags
);

    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_Z] = (i_val == '0);
        o_flags[FLAG_N] = i_val[WIDTH-1];
        // carry only means something when the adder produced the result
        o_flags[FLAG_C] = i_f & i_carry;
`ifdef ALU_RESULT_PARITY_EN
        o_flags[FLAG_P] = ~^i_val;
`endif
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: registers results with flags in a 2-entry FIFO and
// keeps the architectural flags. Ports: clk, reset_n, bus (slave). Macro: ALU_RESULT_PARITY_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_result_stage_if.slave  bus
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    entry_t            r_e0;
    entry_t            r_e1;
    logic              r_sf0;
    logic              r_sf1;
    logic [1:0]        r_count;
    logic [FLAG_W-1:0] r_flags;

    logic [FLAG_W-1:0] w_flags;
    entry_t            w_new;
    logic              w_push;
    logic              w_pop;
    logic              w_unused_ctrl;

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .i_val   (bus.in_val),
        .i_f     (bus.in_ctrl[CTL_F]),
        .i_carry (bus.in_carry),
        .o_flags (w_flags)
    );

    assign w_unused_ctrl = ^{bus.in_ctrl[CTL_ZX:CTL_NY], bus.in_ctrl[CTL_NO]};

    assign w_new  = '{flags: w_flags, val: bus.in_val};
    assign w_push = bus.in_valid && bus.in_ready;
    assign w_pop  = bus.out_valid && bus.out_ready;

    assign bus.in_ready  = (r_count != FULL);
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_val   = r_e0.val;
    assign bus.out_flags = r_e0.flags;
    assign bus.flags     = r_flags;
    assign bus.count     = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_sf0   <= 1'b0;
            r_sf1   <= 1'b0;
            r_count <= 2'd0;
            r_flags <= '0;
        end else begin
            if (w_pop && r_sf0) begin
                r_flags <= r_e0.flags;
            end
            // r_e0 is always the head; r_e1 only holds the second entry
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_e0    <= w_new;
                        r_sf0   <= bus.in_setflags;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_e0  <= w_new;
                        r_sf0 <= bus.in_setflags;
                    end else if (w_push) begin
                        r_e1    <= w_new;
                        r_sf1   <= bus.in_setflags;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_e0    <= r_e1;
                        r_sf0   <= r_sf1;
                        r_count <= 2'd1;
                    end
                end
                default: begin
                    r_count <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
// Expected values are hand-computed {C,N,Z}; parity is appended when enabled.
module tb_alu_result_stage;
    import alu_pkg::*;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    alu_result_stage_if #(.WIDTH(16)) bus ();

    alu_result_stage #(
        .WIDTH (16),
        .DEPTH (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ef(input logic [15:0] v,
                                       input logic [2:0] cnz);
`ifdef ALU_RESULT_PARITY_EN
        return {28'd0, ~^v, cnz};
`else
        return {29'd0, cnz};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] val,
                         input logic f, input logic c, input logic sf);
        bus.in_valid    = v;
        bus.in_val      = val;
        bus.in_ctrl     = {4'b0000, f, 1'b0};
        bus.in_carry    = c;
        bus.in_setflags = sf;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("rst_count", 32'(bus.count), 0);
        check("rst_ovalid", 32'(bus.out_valid), 0);
        check("rst_iready", 32'(bus.in_ready), 1);
        check("rst_flags", 32'(bus.flags), 0);
        check("rst_oval", 32'(bus.out_val), 0);
        check("rst_oflags", 32'(bus.out_flags), 0);
        reset_n = 1'b1;

        // zero result with adder carry, flag-setting
        drive(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("t1_ovalid", 32'(bus.out_valid), 1);
        check("t1_oflags", 32'(bus.out_flags), ef(16'h0000, 3'b101));
        check("t1_count", 32'(bus.count), 1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("t1_flags", 32'(bus.flags), ef(16'h0000, 3'b101));
        check("t1_count0", 32'(bus.count), 0);
        check("t1_ovalid0", 32'(bus.out_valid), 0);

        // fill, overflow attempt, drain
        drive(1'b1, 16'h8001, 1'b0, 1'b1, 1'b1);
        step();
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        step();
        check("t2_count2", 32'(bus.count), 2);
        check("t2_iready", 32'(bus.in_ready), 0);
        drive(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("t2_full", 32'(bus.count), 2);
        check("t2_head", 32'(bus.out_val), 32'h8001);
        check("t2_hflags", 32'(bus.out_flags), ef(16'h8001, 3'b010));
        bus.out_ready = 1'b1;
        step();
        check("t2_second", 32'(bus.out_val), 32'h1234);
        check("t2_sflags", 32'(bus.out_flags), ef(16'h1234, 3'b000));
        check("t2_arch", 32'(bus.flags), ef(16'h8001, 3'b010));
        check("t2_count1", 32'(bus.count), 1);
        step();
        bus.out_ready = 1'b0;
        check("t2_empty", 32'(bus.count), 0);
        check("t2_arch_keep", 32'(bus.flags), ef(16'h8001, 3'b010));

        // simultaneous push and pop at count 1
        drive(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        check("t3_count", 32'(bus.count), 1);
        check("t3_head", 32'(bus.out_val), 32'h0006);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("t3_drain", 32'(bus.count), 0);

        // non-flag-setting pop and stable hold
        drive(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_val", 32'(bus.out_val), 0);
            check("t4_hold_flg", 32'(bus.out_flags), ef(16'h0000, 3'b101));
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("t4_count", 32'(bus.count), 0);
        check("t4_arch", 32'(bus.flags), ef(16'h8001, 3'b010));

        // asynchronous reset mid-cycle while full
        drive(1'b1, 16'h1111, 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b1, 16'h2222, 1'b0, 1'b0, 1'b1);
        step();
        check("t5_full", 32'(bus.count), 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rcount", 32'(bus.count), 0);
        check("t5_rvalid", 32'(bus.out_valid), 0);
        check("t5_rflags", 32'(bus.flags), 0);
        check("t5_rready", 32'(bus.in_ready), 1);
        step();
        check("t5_nopush", 32'(bus.count), 0);
        reset_n = 1'b1;
        drive(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("t5_count1", 32'(bus.count), 1);
        check("t5_head", 32'(bus.out_val), 32'h00AA);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("t5_alone", 32'(bus.count), 0);

`ifdef ALU_RESULT_PARITY_EN
        drive(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("t6_p_even", 32'(bus.out_flags), 32'b1000);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("t6_p_odd", 32'(bus.out_flags), 32'b0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
